// File: rtl/div_pkg.sv
// Shared constants, state encoding and sign helper for the sequential divider.
package div_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic logic [WIDTH-1:0] neg_if(input logic en, input logic [WIDTH-1:0] x);
    return en ? (~x + WIDTH'(1)) : x;
  endfunction

endpackage

// File: rtl/add_full_1b.sv
// One-bit full adder cell used to build ripple arithmetic.
module add_full_1b (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/sub_full_33b.sv
// 33-bit ripple subtractor (a - b) from full-adder cells; borrow is the result MSB.
module sub_full_33b (
  input  logic [32:0] a_i,
  input  logic [32:0] b_i,
  output logic [31:0] diff_o,
  output logic        borrow_o
);

  localparam int unsigned N = 33;

  logic [N:0]   carry;
  logic [N-1:0] sum;
  logic         unused_cout;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_bit
    add_full_1b u_fa (
      .a_i    (a_i[i]),
      .b_i    (~b_i[i]),
      .cin_i  (carry[i]),
      .sum_o  (sum[i]),
      .cout_o (carry[i+1])
    );
  end

  // The top bit of the difference doubles as the "went negative" flag.
  assign diff_o      = sum[N-2:0];
  assign borrow_o    = sum[N-1];
  assign unused_cout = carry[N];

endmodule

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider: one quotient bit per clock, signed/unsigned,
// deterministic divide-by-zero result, fixed 33-cycle latency.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = div_pkg::WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] dvdnd,
  input  logic [WIDTH-1:0] dvsor,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] remd,
  output logic             valid,
  output logic             div_zero,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] raw_q, raw_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remd_q, remd_d;
  logic             valid_q, valid_d;
  logic             div_zero_q, div_zero_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] t_diff;
  logic             t_borrow;

  sub_full_33b u_sub (
    .a_i      ({r_q, q_q[WIDTH-1]}),
    .b_i      ({1'b0, b_q}),
    .diff_o   (t_diff),
    .borrow_o (t_borrow)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    r_d        = r_q;
    q_d        = q_q;
    b_d        = b_q;
    raw_d      = raw_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    dz_d       = dz_q;
    quot_d     = quot_q;
    remd_d     = remd_q;
    valid_d    = 1'b0;
    div_zero_d = div_zero_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sa_d    = sgn & dvdnd[WIDTH-1];
          sb_d    = sgn & dvsor[WIDTH-1];
          q_d     = neg_if(sgn & dvdnd[WIDTH-1], dvdnd);
          b_d     = neg_if(sgn & dvsor[WIDTH-1], dvsor);
          dz_d    = (dvsor == '0);
          raw_d   = dvdnd;
          r_d     = '0;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        // A restored remainder is below the divisor, so its shifted-out bit is zero.
        q_d   = {q_q[WIDTH-2:0], ~t_borrow};
        r_d   = t_borrow ? {r_q[WIDTH-2:0], q_q[WIDTH-1]} : t_diff;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == ITER_LAST) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (dz_q) begin
          quot_d = '1;
          remd_d = raw_q;
        end else begin
          quot_d = neg_if(sa_q ^ sb_q, q_q);
          remd_d = neg_if(sa_q, r_q);
        end
        div_zero_d = dz_q;
        valid_d    = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      r_q        <= '0;
      q_q        <= '0;
      b_q        <= '0;
      raw_q      <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      dz_q       <= 1'b0;
      quot_q     <= '0;
      remd_q     <= '0;
      valid_q    <= 1'b0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      r_q        <= r_d;
      q_q        <= q_d;
      b_q        <= b_d;
      raw_q      <= raw_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      dz_q       <= dz_d;
      quot_q     <= quot_d;
      remd_q     <= remd_d;
      valid_q    <= valid_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
    end
  end

  assign quot     = quot_q;
  assign remd     = remd_q;
  assign valid    = valid_q;
  assign div_zero = div_zero_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, control corner cases, random ops.
module tb_seq_divider;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        sgn;
  logic [31:0] dvdnd;
  logic [31:0] dvsor;
  logic [31:0] quot;
  logic [31:0] remd;
  logic        valid;
  logic        div_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  seq_divider #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .sgn      (sgn),
    .dvdnd    (dvdnd),
    .dvsor    (dvsor),
    .quot     (quot),
    .remd     (remd),
    .valid    (valid),
    .div_zero (div_zero),
    .busy     (busy)
  );

  typedef struct {
    string       name;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eq;
    logic [31:0] er;
    logic        edz;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic, truncating division, remainder follows the dividend.
  task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic dz);
    int sa;
    int sb;
    dz = (b == 32'd0);
    if (dz) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa = a;
      sb = b;
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endtask

  // Launch one op and wait (bounded) for valid; lat counts edges after the start edge.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    @(negedge clock);
    start = 1'b1;
    sgn   = s;
    dvdnd = a;
    dvsor = b;
    @(posedge clock);
    #1;
    start = 1'b0;
    lat = 0;
    while (!valid && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic run_check(input string name, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eq,
                           input logic [31:0] er, input logic edz);
    int lat;
    do_op(s, a, b, lat);
    check({name, " latency"}, 32'(lat), 32'd33);
    check({name, " quot"}, quot, eq);
    check({name, " remd"}, remd, er);
    check({name, " div_zero"}, 32'(div_zero), 32'(edz));
    check({name, " busy in valid cycle"}, 32'(busy), 32'd0);
    @(posedge clock);
    #1;
    check({name, " valid width"}, 32'(valid), 32'd0);
    check({name, " quot hold"}, quot, eq);
  endtask

  vec_t vecs[$];

  initial begin
    int          n_valid;
    int          first_v;
    int          lat;
    int          last_v;
    logic [31:0] mq;
    logic [31:0] mr;
    logic        mdz;
    logic        rs;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs.push_back('{"s 100/7",       1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0});
    vecs.push_back('{"s -100/7",      1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0});
    vecs.push_back('{"s 100/-7",      1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0});
    vecs.push_back('{"s -100/-7",     1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0});
    vecs.push_back('{"s min/-1",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0});
    vecs.push_back('{"u min/max",     1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0});
    vecs.push_back('{"s 1234/0",      1'b1, 32'd1234,       32'd0,          32'hFFFF_FFFF,  32'h0000_04D2,  1'b1});
    vecs.push_back('{"u 9/3",         1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0});
    vecs.push_back('{"u 1234/0",      1'b0, 32'd1234,       32'd0,          32'hFFFF_FFFF,  32'h0000_04D2,  1'b1});
    vecs.push_back('{"s 9/3",         1'b1, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0});
    vecs.push_back('{"s -1234/0",     1'b1, 32'hFFFF_FB2E,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FB2E,  1'b1});
    vecs.push_back('{"u max/1",       1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0});
    vecs.push_back('{"u 5/10",        1'b0, 32'd5,          32'd10,         32'd0,          32'd5,          1'b0});
    vecs.push_back('{"s min/1",       1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0});
    vecs.push_back('{"u max/max",     1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0});

    reset = 1'b0;
    start = 1'b0;
    sgn   = 1'b0;
    dvdnd = '0;
    dvsor = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset quot", quot, 32'd0);
    check("reset remd", remd, 32'd0);
    check("reset valid", 32'(valid), 32'd0);
    check("reset div_zero", 32'(div_zero), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) begin
      run_check(vecs[i].name, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].er, vecs[i].edz);
    end

    // start pulse mid-operation must be ignored
    @(negedge clock);
    start = 1'b1; sgn = 1'b0; dvdnd = 32'd1000; dvsor = 32'd3;
    @(posedge clock);
    #1;
    start = 1'b0;
    n_valid = 0;
    first_v = 0;
    for (int n = 1; n <= 70; n++) begin
      @(posedge clock);
      #1;
      if (n == 4) begin
        start = 1'b1; dvdnd = 32'd7; dvsor = 32'd1;
        check("busy mid-op", 32'(busy), 32'd1);
      end
      if (n == 5) start = 1'b0;
      if (valid) begin
        n_valid++;
        if (first_v == 0) begin
          first_v = n;
          check("ignored start quot", quot, 32'd333);
          check("ignored start remd", remd, 32'd1);
        end
      end
    end
    check("ignored start valid count", 32'(n_valid), 32'd1);
    check("ignored start latency", 32'(first_v), 32'd33);

    // reset in the middle of an operation
    @(negedge clock);
    start = 1'b1; sgn = 1'b0; dvdnd = 32'd1000; dvsor = 32'd7;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("mid reset quot", quot, 32'd0);
    check("mid reset remd", remd, 32'd0);
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset valid", 32'(valid), 32'd0);
    reset = 1'b1;
    n_valid = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock);
      #1;
      if (valid) n_valid++;
    end
    check("no valid after reset", 32'(n_valid), 32'd0);
    run_check("u 50/8 after reset", 1'b0, 32'd50, 32'd8, 32'd6, 32'd2, 1'b0);

    // start held high: back-to-back results every 34 cycles
    @(negedge clock);
    start = 1'b1; sgn = 1'b0; dvdnd = 32'd200; dvsor = 32'd9;
    @(posedge clock);
    n_valid = 0;
    last_v = 0;
    for (int n = 1; n <= 104; n++) begin
      @(posedge clock);
      #1;
      if (valid) begin
        n_valid++;
        check("held quot", quot, 32'd22);
        check("held remd", remd, 32'd2);
        check("held valid spacing", 32'(n - last_v), (last_v == 0) ? 32'd33 : 32'd34);
        last_v = n;
      end
    end
    check("held valid count", 32'(n_valid), 32'd3);
    start = 1'b0;
    repeat (40) @(posedge clock);

    // randomized operations against the arithmetic model
    for (int k = 0; k < 150; k++) begin
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       ra = 32'h8000_0000;
        1:       ra = $urandom_range(0, 255);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF - $urandom_range(0, 15);
        3:       rb = $urandom >> $urandom_range(1, 30);
        default: rb = $urandom;
      endcase
      model(rs, ra, rb, mq, mr, mdz);
      do_op(rs, ra, rb, lat);
      check("rand latency", 32'(lat), 32'd33);
      check("rand quot", quot, mq);
      check("rand remd", remd, mr);
      check("rand div_zero", 32'(div_zero), 32'(mdz));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
